chess_game_ctrl: RTL
====================

# chess_game_ctrl

Game-level sequencer sitting above the board datapath (board initializer/move writer) and the board memory. On `start` it commands a board initialization and waits for completion. It then runs the turn loop: latch a selected origin square, read and check the piece there, latch a destination, check it, and issue one move command to the datapath. It tracks whose turn it is and counts completed moves.

## Interface
- No parameters; board is fixed 8x8 with 4-bit piece codes: 0 empty, 1-6 black, 7-12 white.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and all outputs to reset values.
- `start` in 1: pulse; begins a new game (also restarts from a select state).
- `key_valid` in 1: one-cycle strobe; `key_x`/`key_y` name the chosen square.
- `key_x`, `key_y` in 3: chosen square coordinates.
- `rd_x`, `rd_y` out 3: board memory read address (registered).
- `rd_data` in 4: board memory read data, valid the cycle after the address is presented.
- `initialize_board` out 1: one-cycle pulse to datapath.
- `initialize_complete` in 1: datapath init-done indication (level, sampled).
- `piece_x`, `piece_y`, `move_x`, `move_y` out 3: latched origin/destination to datapath.
- `piece_to_move` out 4: latched origin piece code.
- `move_piece` out 1: one-cycle pulse to datapath.
- `turn` out 1: 0 white to move, 1 black to move.
- `move_count` out 8: completed moves, saturates at 255.
- `illegal` out 1: one-cycle pulse when a selection is rejected.
- `busy` out 1: high in every state except SEL_PIECE and SEL_DEST.

## Operation
- States: IDLE, INIT, WAIT_INIT, SEL_PIECE, RD_PIECE, CHK_PIECE, SEL_DEST, RD_DEST, CHK_DEST, MOVE, MOVE_WAIT.
- IDLE: `start` -> INIT. INIT: assert `initialize_board` one cycle; clear `turn` and `move_count` -> WAIT_INIT.
- WAIT_INIT: stay until `initialize_complete`=1 -> SEL_PIECE.
- SEL_PIECE: `key_valid` latches `piece_x/y` and drives `rd_x/y` -> RD_PIECE. RD_PIECE: one cycle -> CHK_PIECE.
- CHK_PIECE: `rd_data`=0 -> `illegal`, SEL_PIECE. Otherwise latch `piece_to_move` -> SEL_DEST. Ownership rule only under OWNER_CHECK_EN.
- SEL_DEST: `key_valid` on the same square as the origin cancels the selection -> SEL_PIECE with no `illegal`. Any other square latches `move_x/y` and drives `rd_x/y` -> RD_DEST -> CHK_DEST.
- CHK_DEST: accept -> MOVE. Reject (only under OWNER_CHECK_EN) -> `illegal`, SEL_DEST with the origin kept.
- MOVE: pulse `move_piece` one cycle -> MOVE_WAIT.
- MOVE_WAIT: 5-cycle counter, then toggle `turn`, increment `move_count` unless it is 255 -> SEL_PIECE.
- `key_valid` is ignored outside SEL_PIECE/SEL_DEST.
- `start` is honoured in IDLE, SEL_PIECE and SEL_DEST (-> INIT) and ignored elsewhere.
- `piece_*`, `move_*` and `piece_to_move` hold their values until next overwritten.

## Timing
- Reset values: state IDLE; all outputs 0.
- key_valid -> `illegal` or acceptance: 3 cycles (SEL, RD, CHK).
- `start` in IDLE -> `initialize_board` high the next cycle.
- `move_piece` high exactly 1 cycle. Next SEL_PIECE is entered 6 cycles after `move_piece`. `turn` toggles on the same edge.
- `initialize_complete` is sampled only in WAIT_INIT; a pulse of one cycle is sufficient.
- Reset asserted mid-move or mid-init: immediate IDLE, pulses cleared. The datapath completes or aborts independently.

## Configuration
- `CHESS_OWNER_CHECK_EN` defined, CHK_PIECE: reject if the piece colour ≠ `turn` (white 7-12 needs turn=0; black 1-6 needs turn=1).
- `CHESS_OWNER_CHECK_EN` defined, CHK_DEST: reject if the destination holds a piece of the mover's colour.
- Undefined: only empty-origin is rejected, and any destination is accepted. `turn` still toggles.

## Test plan
- Reset, `start` -> `initialize_board` pulse next cycle. Hold `initialize_complete` low 10 cycles, then pulse it -> `busy`=0, state SEL_PIECE, `turn`=0, `move_count`=0.
- Select (4,6), rd_data=7, then dest (4,4), rd_data=0 -> `move_piece` pulse with piece 4,6 / move 4,4 / code 7. `turn`=1 and `move_count`=1 six cycles later.
- Select empty square (3,3), rd_data=0 -> `illegal` pulse 3 cycles after key. State SEL_PIECE; no `move_piece`.
- Select (0,6) then same square (0,6) -> return to SEL_PIECE, no `illegal`, no `move_piece`.
- With OWNER_CHECK_EN, turn=0: origin code 1 -> `illegal`. Origin code 10, dest code 7 -> `illegal`, stays SEL_DEST. Without the macro both are accepted.
- Assert `reset` during MOVE_WAIT -> all outputs 0 immediately. 256 moves -> `move_count` holds 255.

Source files
------------

// File: rtl/chess_game_ctrl.sv
// chess_game_ctrl - game-level sequencer above the board datapath and board memory.
// Runs board initialization, then the turn loop: origin select/read/check, destination
// select/read/check, one move command, then a fixed settle period before the next turn.
// Optional feature: define CHESS_OWNER_CHECK_EN to enforce piece ownership on the
// origin (colour must match turn) and on the destination (no capture of own colour).
module chess_game_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       key_valid,
   input  logic [2:0] key_x,
   input  logic [2:0] key_y,
   output logic [2:0] rd_x,
   output logic [2:0] rd_y,
   input  logic [3:0] rd_data,
   output logic       initialize_board,
   input  logic       initialize_complete,
   output logic [2:0] piece_x,
   output logic [2:0] piece_y,
   output logic [2:0] move_x,
   output logic [2:0] move_y,
   output logic [3:0] piece_to_move,
   output logic       move_piece,
   output logic       turn,
   output logic [7:0] move_count,
   output logic       illegal,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      WAIT_INIT,
      SEL_PIECE,
      RD_PIECE,
      CHK_PIECE,
      SEL_DEST,
      RD_DEST,
      CHK_DEST,
      MOVE,
      MOVE_WAIT
   } state_t;

   // MOVE_WAIT lasts five cycles: counter values 0..4
   localparam logic [2:0] WAIT_LAST = 3'd4;

   state_t     state;
   state_t     next_state;
   logic [2:0] wait_cnt;
   logic       wait_done;
   logic       same_square;
   logic       origin_ok;
   logic       dest_ok;
   logic       illegal_nxt;

`ifdef CHESS_OWNER_CHECK_EN
   function automatic logic is_white(input logic [3:0] code);
      return (code >= 4'd7) && (code <= 4'd12);
   endfunction

   function automatic logic is_black(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd6);
   endfunction

   // Origin must be a piece of the side to move; destination must not hold the mover's colour
   assign origin_ok = turn ? is_black(rd_data) : is_white(rd_data);
   assign dest_ok   = is_white(piece_to_move) ? !is_white(rd_data) : !is_black(rd_data);
`else
   // Only an empty origin is refused; any destination is accepted
   assign origin_ok = (rd_data != 4'd0);
   assign dest_ok   = 1'b1;
`endif

   assign wait_done   = (wait_cnt == WAIT_LAST);
   assign same_square = (key_x == piece_x) && (key_y == piece_y);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode and rejection detection
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      next_state  = state;
      illegal_nxt = 1'b0;
      unique case (state)
         IDLE:      if (start) next_state = INIT;
         INIT:      next_state = WAIT_INIT;
         WAIT_INIT: if (initialize_complete) next_state = SEL_PIECE;
         SEL_PIECE: begin
            if (start)          next_state = INIT;
            else if (key_valid) next_state = RD_PIECE;
         end
         RD_PIECE:  next_state = CHK_PIECE;
         CHK_PIECE: begin
            if (origin_ok) begin
               next_state = SEL_DEST;
            end else begin
               next_state  = SEL_PIECE;
               illegal_nxt = 1'b1;
            end
         end
         SEL_DEST: begin
            if (start)          next_state = INIT;
            else if (key_valid) next_state = same_square ? SEL_PIECE : RD_DEST;
         end
         RD_DEST:   next_state = CHK_DEST;
         CHK_DEST: begin
            if (dest_ok) begin
               next_state = MOVE;
            end else begin
               next_state  = SEL_DEST;
               illegal_nxt = 1'b1;
            end
         end
         MOVE:      next_state = MOVE_WAIT;
         MOVE_WAIT: if (wait_done) next_state = SEL_PIECE;
         default:   next_state = IDLE;
      endcase
   end

   // Registered outputs, latched coordinates, turn bookkeeping and settle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_x             <= '0;
         rd_y             <= '0;
         initialize_board <= 1'b0;
         piece_x          <= '0;
         piece_y          <= '0;
         move_x           <= '0;
         move_y           <= '0;
         piece_to_move    <= '0;
         move_piece       <= 1'b0;
         turn             <= 1'b0;
         move_count       <= '0;
         illegal          <= 1'b0;
         busy             <= 1'b0;
         wait_cnt         <= '0;
      end else begin
         // Pulses and busy follow the state being entered, so they line up with it
         initialize_board <= (next_state == INIT);
         move_piece       <= (next_state == MOVE);
         illegal          <= illegal_nxt;
         busy             <= (next_state != SEL_PIECE) && (next_state != SEL_DEST);
         wait_cnt         <= (state == MOVE_WAIT) ? wait_cnt + 3'd1 : 3'd0;

         if (next_state == INIT) begin
            turn       <= 1'b0;
            move_count <= '0;
         end else if ((state == MOVE_WAIT) && wait_done) begin
            turn <= ~turn;
            if (move_count != 8'hFF) move_count <= move_count + 8'd1;
         end

         // RD_PIECE is only entered from SEL_PIECE on an accepted key
         if (next_state == RD_PIECE) begin
            piece_x <= key_x;
            piece_y <= key_y;
            rd_x    <= key_x;
            rd_y    <= key_y;
         end

         // RD_DEST is only entered from SEL_DEST on a key naming a different square
         if (next_state == RD_DEST) begin
            move_x <= key_x;
            move_y <= key_y;
            rd_x   <= key_x;
            rd_y   <= key_y;
         end

         if ((state == CHK_PIECE) && origin_ok) piece_to_move <= rd_data;
      end
   end

endmodule
